// File: rtl/sprite_pkg.sv
// Shared constants for the sprite draw engine: FSM state codes, screen size and job types.
// Pure definitions, no logic, so it carries no latency or backpressure behaviour.
package sprite_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DRAW   = 3'd1;
    localparam logic [2:0] FLUSH1 = 3'd2;
    localparam logic [2:0] FLUSH2 = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    localparam logic JOB_BG   = 1'b0;
    localparam logic JOB_CHAR = 1'b1;

endpackage

// File: rtl/sprite_draw_engine_screen_addr_calc.sv
// Linear framebuffer address y*320 + x from shifts and adds. It has no multiplier.
// Purely combinational, so it adds no latency and never applies backpressure.
module screen_addr_calc
    import sprite_pkg::*;
(
    input  logic [9:0]  px_i,
    input  logic [8:0]  py_i,
    output logic [16:0] addr_o
);

    // 320 = 256 + 64
    assign addr_o = 17'({py_i, 8'b0}) + 17'({py_i, 6'b0}) + 17'(px_i);

endmodule

// File: rtl/sprite_draw_engine.sv
// Streams a sprite or the background under it to the VGA plot port, one pixel per clock.
// Two-stage pipeline with done at N+3. No stalls. SPRITE_TRANSPARENCY_EN keys out KEY_COLOUR in character jobs.
module sprite_draw_engine
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8,
    parameter int COLOUR_W = 9,
    parameter logic [COLOUR_W-1:0] KEY_COLOUR = 9'h1C7,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
)(
    input  logic                                  clock,
    input  logic                                  resetn,
    input  logic                                  drawBG,
    input  logic                                  drawChar,
    input  logic [8:0]                            xCoordinate,
    input  logic [7:0]                            yCoordinate,
    output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]  charAddr,
    input  logic [COLOUR_W-1:0]                   charData,
    output logic [16:0]                           bgAddr,
    input  logic [COLOUR_W-1:0]                   bgData,
    output logic [8:0]                            vgaX,
    output logic [7:0]                            vgaY,
    output logic [COLOUR_W-1:0]                   colour,
    output logic                                  plot,
    output logic                                  doneBG,
    output logic                                  doneChar
);

    localparam int AW  = $clog2(SPRITE_W*SPRITE_H);
    localparam int CXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int CYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic [9:0] X_LIM = 10'(SCREEN_W);
    localparam logic [8:0] Y_LIM = 9'(SCREEN_H);
`ifdef SPRITE_TRANSPARENCY_EN
    localparam logic KEY_EN = 1'b1;
`else
    localparam logic KEY_EN = 1'b0;
`endif

    logic [2:0]          state_q, state_d;
    logic                job_q, job_d;
    logic [8:0]          x0_q, x0_d;
    logic [7:0]          y0_q, y0_d;
    logic [CXW-1:0]      cx_q, cx_d;
    logic [CYW-1:0]      cy_q, cy_d;

    logic                s1_vld_q;
    logic                s1_job_q;
    logic [9:0]          s1_px_q;
    logic [8:0]          s1_py_q;

    logic [8:0]          vgaX_q, vgaX_d;
    logic [7:0]          vgaY_q, vgaY_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;

    logic                drawing;
    logic [9:0]          px;
    logic [8:0]          py;
    logic [16:0]         bg_addr_calc;
    logic                key_hit;

    assign drawing = (state_q == DRAW);
    assign px      = {1'b0, x0_q} + 10'(cx_q);
    assign py      = {1'b0, y0_q} + 9'(cy_q);

    screen_addr_calc u_addr (
        .px_i   (px),
        .py_i   (py),
        .addr_o (bg_addr_calc)
    );

    assign charAddr = drawing ? (AW'(cy_q) * AW'(SPRITE_W) + AW'(cx_q)) : '0;
    assign bgAddr   = drawing ? bg_addr_calc : 17'd0;

    always_comb begin
        state_d = state_q;
        job_d   = job_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        case (state_q)
            IDLE: begin
                if (drawBG || drawChar) begin
                    job_d   = drawBG ? JOB_BG : JOB_CHAR;
                    x0_d    = xCoordinate;
                    y0_d    = yCoordinate;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (cx_q == CXW'(SPRITE_W - 1)) begin
                    cx_d = '0;
                    if (cy_q == CYW'(SPRITE_H - 1)) begin
                        cy_d    = '0;
                        state_d = FLUSH1;
                    end else begin
                        cy_d = cy_q + CYW'(1);
                    end
                end else begin
                    cx_d = cx_q + CXW'(1);
                end
            end
            FLUSH1:  state_d = FLUSH2;
            FLUSH2:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ROM data arrives alongside stage 1, so the key test is made on the live read port.
    assign key_hit = KEY_EN && (s1_job_q == JOB_CHAR) && (charData == KEY_COLOUR);

    always_comb begin
        vgaX_d   = vgaX_q;
        vgaY_d   = vgaY_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        if (s1_vld_q) begin
            vgaX_d   = s1_px_q[8:0];
            vgaY_d   = s1_py_q[7:0];
            colour_d = (s1_job_q == JOB_CHAR) ? charData : bgData;
            plot_d   = (s1_px_q < X_LIM) && (s1_py_q < Y_LIM) && !key_hit;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            job_q    <= JOB_BG;
            x0_q     <= '0;
            y0_q     <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            s1_vld_q <= 1'b0;
            s1_job_q <= JOB_BG;
            s1_px_q  <= '0;
            s1_py_q  <= '0;
            vgaX_q   <= '0;
            vgaY_q   <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            job_q    <= job_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            s1_vld_q <= drawing;
            s1_job_q <= job_q;
            s1_px_q  <= px;
            s1_py_q  <= py;
            vgaX_q   <= vgaX_d;
            vgaY_q   <= vgaY_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
        end
    end

    assign vgaX     = vgaX_q;
    assign vgaY     = vgaY_q;
    assign colour   = colour_q;
    assign plot     = plot_q;
    assign doneBG   = (state_q == DONE) && (job_q == JOB_BG);
    assign doneChar = (state_q == DONE) && (job_q == JOB_CHAR);

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed and randomised jobs against a pixel-list reference model of the sprite draw engine.
module tb_sprite_draw_engine;

    localparam int W   = 8;
    localparam int H   = 8;
    localparam int N   = W * H;
    localparam int KEY = 9'h1C7;

    logic        clock = 1'b0;
    logic        resetn;
    logic        drawBG, drawChar;
    logic [8:0]  xCoordinate;
    logic [7:0]  yCoordinate;
    logic [5:0]  charAddr;
    logic [8:0]  charData = '0;
    logic [16:0] bgAddr;
    logic [8:0]  bgData = '0;
    logic [8:0]  vgaX;
    logic [7:0]  vgaY;
    logic [8:0]  colour;
    logic        plot, doneBG, doneChar;

    logic [8:0]  char_rom [N];

    int errors = 0;
    int checks = 0;

    sprite_draw_engine dut (
        .clock       (clock),
        .resetn      (resetn),
        .drawBG      (drawBG),
        .drawChar    (drawChar),
        .xCoordinate (xCoordinate),
        .yCoordinate (yCoordinate),
        .charAddr    (charAddr),
        .charData    (charData),
        .bgAddr      (bgAddr),
        .bgData      (bgData),
        .vgaX        (vgaX),
        .vgaY        (vgaY),
        .colour      (colour),
        .plot        (plot),
        .doneBG      (doneBG),
        .doneChar    (doneChar)
    );

    always #5 clock = ~clock;

    // Registered-read ROMs; the background image holds the low bits of its own address.
    always @(posedge clock) begin
        charData <= char_rom[charAddr];
        bgData   <= bgAddr[8:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic bit transp_on();
`ifdef SPRITE_TRANSPARENCY_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int count_visible(input bit is_bg, input int x0, input int y0);
        int n = 0;
        for (int k = 0; k < N; k++) begin
            int px = x0 + k % W;
            int py = y0 + k / W;
            if (px < 320 && py < 240 && !(!is_bg && transp_on() && char_rom[k] == KEY))
                n++;
        end
        return n;
    endfunction

    // Entered at the negedge of cycle 0 with the request already driven; returns in cycle N+4.
    task automatic run_job(input bit is_bg, input int x0, input int y0, input int exp_count);
        int nplots = 0;
        for (int t = 1; t <= N + 4; t++) begin
            int k, j, px, py, exp_col;
            bit vis;
            @(negedge clock);
            if (t == 1) begin
                xCoordinate = 9'($urandom);
                yCoordinate = 8'($urandom);
            end
            j = t - 1;
            if (j >= 0 && j < N) begin
                chk("charAddr", charAddr, j);
                chk("bgAddr", bgAddr, (y0 + j / W) * 320 + x0 + j % W);
            end else begin
                chk("charAddr_idle", charAddr, 0);
                chk("bgAddr_idle", bgAddr, 0);
            end
            k = t - 3;
            vis = 1'b0;
            px = 0; py = 0; exp_col = 0;
            if (k >= 0 && k < N) begin
                px = x0 + k % W;
                py = y0 + k / W;
                vis = (px < 320) && (py < 240);
                if (!is_bg && transp_on() && char_rom[k] == KEY) vis = 1'b0;
                exp_col = is_bg ? ((py * 320 + px) % 512) : int'(char_rom[k]);
            end
            chk("plot", plot, vis);
            if (vis && plot) begin
                chk("vgaX", vgaX, px);
                chk("vgaY", vgaY, py);
                chk("colour", colour, exp_col);
            end
            if (plot) nplots++;
            chk("doneBG", doneBG, (t == N + 3) && is_bg);
            chk("doneChar", doneChar, (t == N + 3) && !is_bg);
            if (t == N + 3) begin
                xCoordinate = 9'(x0);
                yCoordinate = 8'(y0);
                if (is_bg) drawBG = 1'b0;
                else drawChar = 1'b0;
            end
        end
        chk("plot_count", nplots, exp_count);
    endtask

    initial begin
        int x, y, pos;
        bit b;
        resetn = 1'b0; drawBG = 1'b0; drawChar = 1'b0;
        xCoordinate = '0; yCoordinate = '0;
        for (int i = 0; i < N; i++) char_rom[i] = 9'($urandom_range(0, 255));
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_plot", plot, 0);
        chk("rst_doneBG", doneBG, 0);
        chk("rst_doneChar", doneChar, 0);
        chk("rst_vgaX", vgaX, 0);
        chk("rst_vgaY", vgaY, 0);
        chk("rst_colour", colour, 0);
        chk("rst_charAddr", charAddr, 0);
        chk("rst_bgAddr", bgAddr, 0);
        resetn = 1'b1;
        @(negedge clock);

        // Background restore fully on screen.
        xCoordinate = 9'd95; yCoordinate = 8'd221; drawBG = 1'b1;
        run_job(1'b1, 95, 221, 64);

        // Character draw with an index-pattern ROM.
        for (int i = 0; i < N; i++) char_rom[i] = 9'(i);
        xCoordinate = 9'd126; yCoordinate = 8'd68; drawChar = 1'b1;
        run_job(1'b0, 126, 68, 64);

        // Both requests together: background first, then the held character request.
        x = $urandom_range(0, 300); y = $urandom_range(0, 220);
        xCoordinate = 9'(x); yCoordinate = 8'(y);
        drawBG = 1'b1; drawChar = 1'b1;
        run_job(1'b1, x, y, 64);
        run_job(1'b0, x, y, count_visible(1'b0, x, y));

        // Bottom-right corner clipping.
        xCoordinate = 9'd316; yCoordinate = 8'd236; drawChar = 1'b1;
        run_job(1'b0, 316, 236, 16);

        // Ten key-coloured texels, one per six-entry slice.
        for (int i = 0; i < N; i++) begin
            char_rom[i] = 9'($urandom_range(0, 511));
            if (char_rom[i] == 9'(KEY)) char_rom[i] = 9'd0;
        end
        for (int i = 0; i < 10; i++) begin
            pos = i * 6 + $urandom_range(0, 5);
            char_rom[pos] = 9'(KEY);
        end
        x = $urandom_range(0, 312); y = $urandom_range(0, 232);
        xCoordinate = 9'(x); yCoordinate = 8'(y); drawChar = 1'b1;
        run_job(1'b0, x, y, transp_on() ? 54 : 64);

        // Random jobs anywhere in the coordinate range.
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < N; i++)
                char_rom[i] = ($urandom_range(0, 3) == 0) ? 9'(KEY) : 9'($urandom);
            x = $urandom_range(0, 511); y = $urandom_range(0, 255);
            b = 1'($urandom);
            xCoordinate = 9'(x); yCoordinate = 8'(y);
            if (b) drawBG = 1'b1;
            else drawChar = 1'b1;
            run_job(b, x, y, count_visible(b, x, y));
        end

        // Reset in the middle of a job aborts it silently.
        xCoordinate = 9'd40; yCoordinate = 8'd40; drawChar = 1'b1;
        for (int t = 1; t <= 30; t++) @(negedge clock);
        resetn = 1'b0; drawChar = 1'b0;
        @(negedge clock);
        chk("abort_plot", plot, 0);
        resetn = 1'b1;
        for (int t = 0; t < 80; t++) begin
            @(negedge clock);
            chk("abort_plot", plot, 0);
            chk("abort_doneBG", doneBG, 0);
            chk("abort_doneChar", doneChar, 0);
            chk("abort_charAddr", charAddr, 0);
        end

        // A fresh request after the abort runs to completion.
        xCoordinate = 9'd10; yCoordinate = 8'd20; drawBG = 1'b1;
        run_job(1'b1, 10, 20, 64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
